// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: the store request, the load lookup, the memory write port and status.
// The slave side is the buffer itself; the master side is the EX/MEM stage plus the memory.
interface store_buffer_if #(
  parameter int xw    = 32,
  parameter int dw    = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [xw-1:0] st_addr;
  logic [dw-1:0] st_data;
  logic          st_ready;
  logic [xw-1:0] ld_addr;
  logic          ld_hit;
  logic [dw-1:0] ld_data;
  logic          mem_busy;
  logic [xw-1:0] mem_addr;
  logic [dw-1:0] mem_wdata;
  logic          mem_we;
  logic [CW-1:0] count;
  logic          empty;

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_busy,
    output st_ready, ld_hit, ld_data, mem_addr, mem_wdata, mem_we, count, empty
  );

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_busy,
    input  st_ready, ld_hit, ld_data, mem_addr, mem_wdata, mem_we, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer with load forwarding and a flop-driven data-memory write port.
// Optional macro STB_COALESCE_EN: a store to the youngest entry's address overwrites it in place.
module store_buffer #(
  parameter int xw    = 32,
  parameter int dw    = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  store_buffer_if.slave sb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][xw-1:0] addr_q;
  logic [DEPTH-1:0][dw-1:0] data_q;
  logic [AW-1:0]            head, tail;
  logic [CW-1:0]            cnt;
  logic                     mem_we_q;
  logic [xw-1:0]            mem_addr_q;
  logic [dw-1:0]            mem_wdata_q;

  logic          drain, push, coalesce, ready;
  logic          fwd_hit;
  logic [dw-1:0] fwd_data;

  assign drain = (cnt != '0) && !sb.mem_busy;

`ifdef STB_COALESCE_EN
  logic [AW-1:0] youngest;
  logic          coal_match;
  assign youngest   = tail - AW'(1);
  // Folding into an entry that leaves the queue on this edge would lose the store.
  assign coal_match = (cnt != '0) && (addr_q[youngest] == sb.st_addr)
                    && !((cnt == CW'(1)) && drain);
  assign ready      = (cnt != FULL) || coal_match;
  assign coalesce   = sb.st_valid && coal_match;
  assign push       = sb.st_valid && ready && !coal_match;
`else
  assign ready    = (cnt != FULL);
  assign coalesce = 1'b0;
  assign push     = sb.st_valid && ready;
`endif

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt) && (addr_q[head + AW'(i)] == sb.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head + AW'(i)];
      end
    end
    if (!fwd_hit && mem_we_q && (mem_addr_q == sb.ld_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = mem_wdata_q;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= sb.st_addr;
      data_q[tail] <= sb.st_data;
    end
`ifdef STB_COALESCE_EN
    if (coalesce) data_q[youngest] <= sb.st_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (drain) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= addr_q[head];
        mem_wdata_q <= data_q[head];
        head        <= head + AW'(1);
      end else begin
        mem_we_q <= 1'b0;
      end
      case ({push, drain})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign sb.st_ready  = ready;
  assign sb.ld_hit    = fwd_hit;
  assign sb.ld_data   = fwd_data;
  assign sb.mem_we    = mem_we_q;
  assign sb.mem_addr  = mem_addr_q;
  assign sb.mem_wdata = mem_wdata_q;
  assign sb.count     = cnt;
  assign sb.empty     = (cnt == '0) && !mem_we_q;
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO store buffer between the EX/MEM stage and the data memory.
- Accepts store requests, queues up to DEPTH of them, and drains the oldest one through a registered write port when the memory port is not claimed by a load.
- Forwards the youngest matching pending store to a load lookup so loads never see stale data.
- Drives the data memory's x/dataIn/WE from flops only, so WE never glitches.

Parameters:
- xw, 32, address width in bits.
- dw, 32, data width in bits.
- DEPTH, 4, queue entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store request this cycle.
- st_addr  input  xw  store address.
- st_data  input  dw  store data.
- st_ready  output  1  buffer can accept a store (not full).
- ld_addr  input  xw  load lookup address.
- ld_hit  output  1  pending store matches ld_addr (combinational).
- ld_data  output  dw  forwarded data, valid when ld_hit.
- mem_busy  input  1  memory port used by a load this cycle; inhibits drain issue.
- mem_addr  output  xw  registered write address to data memory.
- mem_wdata  output  dw  registered write data.
- mem_we  output  1  registered write enable; high for exactly one cycle per drained entry.
- count  output  $clog2(DEPTH)+1  number of queued entries, excluding the in-flight write.
- empty  output  1  count==0 and mem_we==0.

Behaviour:
- Reset (rst=1 at an edge):
  - head=tail=count=0; mem_we=0; mem_addr=0; mem_wdata=0.
  - All pending entries, including an in-flight write, are discarded.
  - Outputs after reset: st_ready=1, ld_hit=0, empty=1.
- Push: at an edge with st_valid && st_ready, write {st_addr, st_data} at tail, tail+1 mod DEPTH, count+1.
  - st_ready = (count != DEPTH), derived from registered count only.
  - A store offered while full is not accepted; upstream holds it.
  - No push-through-pop when full.
- Drain: at an edge with count!=0 && !mem_busy, load the head entry into mem_addr/mem_wdata, set mem_we=1, head+1, count-1. Otherwise mem_we=0 and mem_addr/mem_wdata hold.
  - mem_we is never high two cycles for the same entry.
  - Back-to-back drains are allowed: one entry per cycle.
- Latency: a store accepted at edge N is drained at edge N+1 at the earliest, with mem_we high in cycle N+1..N+2. An empty buffer cannot pop at the same edge it pushes.
- Simultaneous push and pop: both take effect; count unchanged.
- Order: entries drain strictly in acceptance order (FIFO), regardless of address.
- Forwarding (combinational, full xw-bit compare):
  - Priority: youngest matching queued entry, then the in-flight register (mem_we=1 and mem_addr==ld_addr), then miss.
  - ld_hit=0 means ld_data=0.
  - The store being pushed in the current cycle is not visible until the next cycle.
- Wrap-around: head and tail wrap modulo DEPTH; full and empty are distinguished by count, not by pointers.
- mem_busy held high: the queue fills and stalls upstream via st_ready; no entry is lost.

Optional Feature:
- Macro STB_COALESCE_EN.
- Defined: a pushed store whose address equals the youngest queued entry (tail-1, count!=0) overwrites that entry's data instead of allocating; count unchanged.
  - Coalescing is allowed when full; st_ready stays (count!=DEPTH) || coalesce_match.
  - Coalescing is suppressed if that entry is being popped at the same edge (count==1 && drain); the store then allocates normally.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset mid-operation: fill 3 entries, assert rst one cycle → count=0, mem_we=0, empty=1, st_ready=1, no further mem_we.
- Single store: st addr=0x10 data=0xDEADBEEF, mem_busy=0 → mem_we=1 exactly one cycle later with mem_addr=0x10, mem_wdata=0xDEADBEEF; empty=1 afterwards.
- Fill and stall: mem_busy=1, push 5 stores addr 1..5 → st_ready=0 after 4 pushes, count=4, 5th held; release mem_busy → drains 1,2,3,4,5 on consecutive cycles.
- Forwarding priority: mem_busy=1, push (0x20,0x11) then (0x20,0x22), ld_addr=0x20 → ld_hit=1, ld_data=0x22; ld_addr=0x24 → ld_hit=0, ld_data=0.
- In-flight forwarding and wrap: single entry (0x30,0x55) drains; during its mem_we cycle ld_addr=0x30 → ld_hit=1, ld_data=0x55. Push/pop 10 entries continuously → pointers wrap and output order matches input.
- STB_COALESCE_EN: mem_busy=1, push (0x40,0x1), (0x40,0x2) → count=1; release mem_busy → one write 0x40/0x2. Without the macro: count=2 and two writes.
